// File: rtl/seq_ratio_div_pkg.sv
// Shared types and constants for the time-shared ratio divider.
// full_scale() gives the saturated quotient value for a given quotient width.
package seq_ratio_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } engine_state_t;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 16;
  localparam int DEF_OUT_W      = 8;

  function automatic logic [31:0] full_scale(input int out_w);
    return (32'd1 << out_w) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_ratio_div_core.sv
// Single-request restoring-division engine computing round(dividend*FS/divisor),
// saturating to FS when dividend >= divisor or divisor == 0.
module seq_ratio_div_core
  import seq_ratio_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  valid,
  output logic [OUT_W-1:0]      result,
  output logic                  result_sat,
  output logic [1:0]            state_dbg
);

  // Handshake: load is honoured only while the engine is IDLE (state_dbg);
  // valid is a one-cycle strobe in WRITE, with result/result_sat stable alongside.

  localparam int OP_W  = (DIVIDEND_W > DIVISOR_W) ? DIVIDEND_W : DIVISOR_W;
  localparam int NUM_W = OP_W + OUT_W;
  localparam int CNT_W = $clog2(OUT_W + 1);
  localparam logic [OUT_W-1:0] FULL = OUT_W'(full_scale(OUT_W));

  engine_state_t state_q, state_d;

  logic [OP_W-1:0]      dvd_ext, dvs_ext;
  logic [NUM_W-1:0]     num;
  logic                 sat_path, sat_flag;
  logic [DIVISOR_W-1:0] rem_q, dvs_q;
  logic [OUT_W-1:0]     shift_q, q_q;
  logic                 sat_path_q, sat_flag_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DIVISOR_W:0]   trial, diff;
  logic                 ge;

  assign dvd_ext  = OP_W'(dividend);
  assign dvs_ext  = OP_W'(divisor);
  assign sat_path = (divisor == '0) || (dvd_ext >= dvs_ext);
  assign sat_flag = (divisor == '0) || (dvd_ext > dvs_ext);
  // Rounding bias folded into the numerator; fits because dividend < divisor here.
  assign num      = NUM_W'(dvd_ext) * NUM_W'(FULL) + NUM_W'(dvs_ext >> 1);

  // The upper bits of num are already below the divisor, so they seed the remainder
  // and only OUT_W iterations remain.
  assign trial = {rem_q, shift_q[OUT_W-1]};
  assign ge    = (trial >= {1'b0, dvs_q});
  assign diff  = trial - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(OUT_W - 1)) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q      <= '0;
      dvs_q      <= '0;
      shift_q    <= '0;
      q_q        <= '0;
      sat_path_q <= 1'b0;
      sat_flag_q <= 1'b0;
      cnt_q      <= '0;
    end else if (state_q == IDLE && load) begin
      rem_q      <= sat_path ? '0 : DIVISOR_W'(num >> OUT_W);
      shift_q    <= num[OUT_W-1:0];
      dvs_q      <= divisor;
      q_q        <= '0;
      sat_path_q <= sat_path;
      sat_flag_q <= sat_flag;
      cnt_q      <= '0;
    end else if (state_q == CALC) begin
      rem_q   <= ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
      shift_q <= shift_q << 1;
      q_q     <= (q_q << 1) | OUT_W'(ge);
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign valid      = (state_q == WRITE);
  assign result     = sat_path_q ? FULL : q_q;
  assign result_sat = sat_flag_q;
  assign state_dbg  = state_q;

endmodule

// File: rtl/seq_ratio_divider.sv
// Multi-channel ratio divider: per-channel operand capture and pending bits,
// round-robin arbitration onto one shared engine, per-channel result registers.
module seq_ratio_divider
  import seq_ratio_div_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH*DIVIDEND_W-1:0] dividend,
  input  logic [NUM_CH*DIVISOR_W-1:0]  divisor,
  output logic [NUM_CH*OUT_W-1:0]      quotient,
  output logic [NUM_CH-1:0]            done,
  output logic [NUM_CH-1:0]            sat,
  output logic [NUM_CH-1:0]            busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DIVIDEND_W-1:0] op_dvd_q [NUM_CH];
  logic [DIVISOR_W-1:0]  op_dvs_q [NUM_CH];
  logic [NUM_CH-1:0]     pending_q, pending_d, grant_mask;
  logic [CH_W-1:0]       ptr_q, grant_ch, inflight_ch_q, inflight_ch_d;
  logic                  inflight_q, inflight_d;
  logic                  grant_found, load;

  logic [1:0]            engine_state;
  logic                  core_valid, core_sat;
  logic [OUT_W-1:0]      core_result;

  // Round-robin: first pending channel at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && pending_q[idx]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(idx);
      end
    end
  end

  assign load       = (engine_state == IDLE) && grant_found;
  assign grant_mask = load ? (NUM_CH'(1) << grant_ch) : '0;
  // A start coinciding with its own grant re-queues: the engine takes the old operands.
  assign pending_d  = (pending_q & ~grant_mask) | start;

  always_comb begin
    inflight_d    = inflight_q;
    inflight_ch_d = inflight_ch_q;
    if (load) begin
      inflight_d    = 1'b1;
      inflight_ch_d = grant_ch;
    end else if (core_valid) begin
      inflight_d    = 1'b0;
    end
  end

  seq_ratio_div_core #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (DIVISOR_W),
    .OUT_W      (OUT_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .dividend   (op_dvd_q[grant_ch]),
    .divisor    (op_dvs_q[grant_ch]),
    .valid      (core_valid),
    .result     (core_result),
    .result_sat (core_sat),
    .state_dbg  (engine_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      ptr_q         <= '0;
      inflight_q    <= 1'b0;
      inflight_ch_q <= '0;
      busy          <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        op_dvd_q[c] <= '0;
        op_dvs_q[c] <= '0;
      end
    end else begin
      pending_q     <= pending_d;
      inflight_q    <= inflight_d;
      inflight_ch_q <= inflight_ch_d;
      busy          <= pending_d | (inflight_d ? (NUM_CH'(1) << inflight_ch_d) : '0);
      if (load) ptr_q <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + CH_W'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (start[c]) begin
          op_dvd_q[c] <= dividend[c*DIVIDEND_W +: DIVIDEND_W];
          op_dvs_q[c] <= divisor[c*DIVISOR_W +: DIVISOR_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient <= '0;
      sat      <= '0;
      done     <= '0;
    end else begin
      done <= '0;
      if (core_valid) begin
        quotient[int'(inflight_ch_q)*OUT_W +: OUT_W] <= core_result;
        sat[inflight_ch_q]                            <= core_sat;
        done[inflight_ch_q]                           <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_ratio_divider.sv
// Directed bench for seq_ratio_divider: transaction-level reference model with a
// per-cycle compare, a done-event scoreboard and hand-computed literal results.
module tb_seq_ratio_divider;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int VW     = 16;
  localparam int OW     = 8;
  localparam int LAT    = OW + 2;

  logic                 tb_clk = 1'b0;
  logic                 rst    = 1'b1;
  logic [NUM_CH-1:0]    start  = '0;
  logic [NUM_CH*DW-1:0] dividend = '0;
  logic [NUM_CH*VW-1:0] divisor  = '0;
  logic [NUM_CH*OW-1:0] quotient;
  logic [NUM_CH-1:0]    done, sat, busy;

  seq_ratio_divider #(
    .NUM_CH (NUM_CH), .DIVIDEND_W (DW), .DIVISOR_W (VW), .OUT_W (OW)
  ) dut (
    .clk      (tb_clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .done     (done),
    .sat      (sat),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 tb_clk = ~tb_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ratio(input longint dvd, input longint dvs,
                                output logic [7:0] q, output logic s);
    longint fs;
    fs = (longint'(1) << OW) - 1;
    if (dvs == 0 || dvd >= dvs) begin
      q = 8'(fs);
      s = (dvs == 0) || (dvd > dvs);
    end else begin
      q = 8'((dvd * fs + dvs / 2) / dvs);
      s = 1'b0;
    end
  endfunction

  logic [7:0]        m_quot [NUM_CH];
  logic [NUM_CH-1:0] m_sat, m_done, m_busy, m_pend;
  longint            m_dvd [NUM_CH];
  longint            m_dvs [NUM_CH];
  int                m_ptr, m_timer, m_ch;
  logic [7:0]        m_res_q;
  logic              m_res_s;
  logic [10:0]       exp_q [$];

  always @(posedge tb_clk) begin
    cyc++;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_quot[c] = '0; m_dvd[c] = 0; m_dvs[c] = 0;
      end
      m_sat = '0; m_done = '0; m_busy = '0; m_pend = '0;
      m_ptr = 0; m_timer = 0; m_ch = 0;
      exp_q.delete();
    end else begin
      m_done = '0;
      if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin
          m_quot[m_ch] = m_res_q;
          m_sat[m_ch]  = m_res_s;
          m_done[m_ch] = 1'b1;
          exp_q.push_back({2'(m_ch), m_res_s, m_res_q});
        end
      end else if (m_pend != '0) begin
        bit found;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          int c;
          c = (m_ptr + i) % NUM_CH;
          if (!found && m_pend[c]) begin
            found = 1'b1;
            m_ch = c;
          end
        end
        m_pend[m_ch] = 1'b0;
        m_ptr = (m_ch + 1) % NUM_CH;
        ratio(m_dvd[m_ch], m_dvs[m_ch], m_res_q, m_res_s);
        m_timer = LAT - 1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (start[c]) begin
          m_dvd[c]  = longint'(dividend[c*DW +: DW]);
          m_dvs[c]  = longint'(divisor[c*VW +: VW]);
          m_pend[c] = 1'b1;
        end
      end
      m_busy = m_pend;
      if (m_timer > 0) m_busy[m_ch] = 1'b1;
    end
  end

  // ---------------- per-cycle compare + done scoreboard ----------------
  always @(negedge tb_clk) begin
    logic [31:0] eq;
    logic [10:0] ev;
    if (chk_en) begin
      eq = '0;
      for (int c = 0; c < NUM_CH; c++) eq[c*OW +: OW] = m_quot[c];
      chk("quotient", quotient, eq);
      chk("done", 32'(done), 32'(m_done));
      chk("sat", 32'(sat), 32'(m_sat));
      chk("busy", 32'(busy), 32'(m_busy));
      for (int c = 0; c < NUM_CH; c++) begin
        if (done[c]) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_extra: ch %0d pulsed done with nothing expected", c);
          end else begin
            ev = exp_q.pop_front();
            chk("done_event", 32'({2'(c), sat[c], quotient[c*OW +: OW]}), 32'(ev));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int ch, input int dvd, input int dvs);
    dividend[ch*DW +: DW] = DW'(dvd);
    divisor[ch*VW +: VW]  = VW'(dvs);
  endtask

  task automatic wait_done(input int ch, output int at);
    at = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge tb_clk);
      if (done[ch]) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic kick(input logic [NUM_CH-1:0] mask, output int t0);
    start = mask;
    @(posedge tb_clk);
    #1 t0 = cyc;
    @(negedge tb_clk);
    start = '0;
  endtask

  task automatic run_one(input int ch, input int dvd, input int dvs,
                         input int lit_q, input int lit_s);
    int t0, at;
    @(negedge tb_clk);
    set_ops(ch, dvd, dvs);
    kick(NUM_CH'(1) << ch, t0);
    wait_done(ch, at);
    chk($sformatf("latency_ch%0d", ch), 32'(at - t0), 32'(LAT));
    chk($sformatf("quot_lit_ch%0d", ch), 32'(quotient[ch*OW +: OW]), 32'(lit_q));
    chk($sformatf("sat_lit_ch%0d", ch), 32'(sat[ch]), 32'(lit_s));
  endtask

  task automatic pulse_reset();
    @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, at;
    bit seen;
    int lit_c [NUM_CH];
    lit_c = '{56, 128, 255, 85};

    // reset with start low, then with start high
    repeat (2) @(posedge tb_clk);
    #1;
    chk_en = 1'b1;
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge tb_clk);
    start = '1;
    @(posedge tb_clk);
    #1 chk("rst_start_busy", 32'(busy), 32'd0);
    @(negedge tb_clk);
    start = '0;
    rst   = 1'b0;

    // basic ratios on ch0
    run_one(0, 22000, 22727, 247, 0);
    run_one(0, 22256, 22727, 250, 0);

    // boundaries on ch1
    run_one(1, 22727, 22727, 255, 0);
    run_one(1, 0,     22727, 0,   0);
    run_one(1, 30000, 22727, 255, 1);
    run_one(1, 1000,  0,     255, 1);

    // contention: all channels in one cycle, pointer back at 0
    pulse_reset();
    @(negedge tb_clk);
    set_ops(0, 5000, 22727);
    set_ops(1, 100, 200);
    set_ops(2, 65535, 65535);
    set_ops(3, 1, 3);
    kick('1, t0);
    for (int c = 0; c < NUM_CH; c++) begin
      wait_done(c, at);
      chk($sformatf("contend_lat_ch%0d", c), 32'(at - t0), 32'(LAT * (c + 1)));
      chk($sformatf("contend_q_ch%0d", c), 32'(quotient[c*OW +: OW]), 32'(lit_c[c]));
    end

    // re-request on ch2 while in flight
    @(negedge tb_clk);
    set_ops(2, 22000, 22727);
    kick(4'b0100, t0);
    repeat (3) @(negedge tb_clk);
    set_ops(2, 11000, 22727);
    start = 4'b0100;
    @(negedge tb_clk);
    start = '0;
    wait_done(2, at);
    chk("rereq_lat1", 32'(at - t0), 32'(LAT));
    chk("rereq_q1", 32'(quotient[2*OW +: OW]), 32'd247);
    wait_done(2, at);
    chk("rereq_lat2", 32'(at - t0), 32'(2 * LAT));
    chk("rereq_q2", 32'(quotient[2*OW +: OW]), 32'd123);

    // reset in the middle of a division
    pulse_reset();
    @(negedge tb_clk);
    set_ops(0, 22000, 22727);
    kick(4'b0001, t0);
    repeat (4) @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge tb_clk);
      if (done[0]) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    chk("midrst_quot", 32'(quotient[OW-1:0]), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    repeat (3) @(negedge tb_clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_ratio_divider.md
Name: seq_ratio_divider

Overview:
- Multi-channel, time-shared sequential divider for the synth datapath.
- Computes a rounded, saturating ratio quotient = round(dividend*(2^OUT_W-1)/divisor) per channel, e.g. for envelope/mixer gain scaling.
- NUM_CH independent requesters share one restoring-division engine through a round-robin arbiter.
- Successor to the single-channel 16/16->8 sequential divider: adds parametrised widths and channel count, rounding, saturation and zero-divisor flagging, and request queuing.

Parameters:
NUM_CH, 4, number of requesting channels (1..16)
DIVIDEND_W, 16, dividend width per channel
DIVISOR_W, 16, divisor width per channel
OUT_W, 8, quotient width; full scale = 2^OUT_W-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  NUM_CH  per-channel request strobe, sampled on rising clk
dividend  in  NUM_CH*DIVIDEND_W  flattened; channel c occupies bits [c*DIVIDEND_W +: DIVIDEND_W]
divisor  in  NUM_CH*DIVISOR_W  flattened, same packing as dividend
quotient  out  NUM_CH*OUT_W  per-channel result register, held until overwritten
done  out  NUM_CH  one-cycle pulse when that channel's quotient updates
sat  out  NUM_CH  valid with the result: set if dividend>divisor or divisor==0
busy  out  NUM_CH  channel has a request pending or in flight

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. All outputs are 0, pending bits and operand registers clear, engine goes to IDLE, arbiter pointer goes to channel 0. Reset mid-division aborts with no done pulse.
- Capture: start[c]=1 at an edge latches that channel's dividend/divisor and sets pending[c].
  - start while pending: operands are overwritten (newest wins); still one request.
  - start while channel c is in flight: new operands are queued as pending; the in-flight result completes normally.
- busy[c] = pending[c] | inflight[c], registered.
- Engine FSM:
  - IDLE: if any pending bit is set, grant the first set channel at or after the pointer (round-robin). Clear its pending bit and load the engine; pointer = grant+1 mod NUM_CH. Go to CALC.
  - CALC: OUT_W restoring-division iterations, one quotient bit per cycle, MSB first. Then WRITE.
  - WRITE: update quotient[c], sat[c]; pulse done[c]; return to IDLE. The next grant happens at the following edge.
- Arithmetic, evaluated at load:
  - If divisor==0 or dividend>=divisor: result = 2^OUT_W-1. sat=1 unless dividend==divisor.
  - Else numerator = dividend*(2^OUT_W-1) + floor(divisor/2), width DIVIDEND_W+OUT_W. Restoring divide by divisor with a DIVISOR_W+1 remainder. Quotient < 2^OUT_W is guaranteed, so no overflow.
  - The saturating path still runs the full CALC count, so latency is data-independent.
- Latency: start sampled at edge N on an idle engine -> grant at N+1, WRITE at N+OUT_W+2. done is high for the cycle following edge N+OUT_W+2 (10 cycles for OUT_W=8).
- Throughput: one result per OUT_W+2 cycles under continuous load.
- Simultaneous starts on several channels: all are captured in the same cycle and served in round-robin order.
- sat and quotient of other channels are unaffected by a write.

Decomposition:
- Package seq_ratio_div_pkg holds:
  - engine state enum {IDLE, CALC, WRITE}
  - default width constants
  - function full_scale(OUT_W)
- Sub-module seq_ratio_div_core: single-request engine with load/operands in and result/sat/valid out.
- Top level holds capture registers, pending bits, the arbiter and per-channel output registers.

Test Plan:
- Reset check: rst=1 for 2 cycles with start held 0 -> all outputs 0; rst=1 with start=4'b1111 -> busy stays 0.
- Basic ratio: ch0 dividend 22000, divisor 22727, start at edge N -> done[0] at N+10, quotient 247, sat 0. Repeat with dividend 22256 -> 250.
- Boundaries on ch1, divisor 22727:
  - dividend 22727 -> 255, sat 0
  - dividend 0 -> 0
  - dividend 30000 -> 255, sat 1
  - divisor 0 -> 255, sat 1
- Contention: ch0..ch3 start in the same cycle with distinct operands -> done pulses at N+10, +20, +30, +40 in order 0,1,2,3; results are independently correct.
- Re-request: ch2 start at N, then again at N+4 with dividend 11000, divisor 22727 -> first result at N+10, second result 123 at N+20.
- Mid-operation reset: ch0 started, rst asserted at N+5 for 1 cycle -> no done pulse, quotient stays 0, busy 0.
